// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative RV32M multiply/divide unit beside the main ALU.
// Accepts one op from EX, stalls the pipeline while it iterates one bit per
// cycle, and returns the result with a single-cycle done pulse.
//
// Ports:
//   clk     in   rising-edge clock
//   rst_n   in   asynchronous active-low reset
//   start   in   EX-stage request (valid M-op)
//   funct3  in   000 MUL 001 MULH 010 MULHSU 011 MULHU 100 DIV 101 DIVU 110 REM 111 REMU
//   a, b    in   rs1 / rs2 operands
//   flush   in   kills the op in flight
//   stall   out  hold IF/ID/EX pipeline registers
//   busy    out  op accepted and not yet completed
//   done    out  one-cycle result-valid pulse
//   result  out  op result, holds last value between ops
module muldiv_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] MinNeg = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e             state_q;
  logic [2:0]         op_q;
  logic [WIDTH-1:0]   opb_q;   // multiplicand (mul) or divisor (div) magnitude
  logic [2*WIDTH-1:0] prod_q;  // mul: {acc, multiplier}; div: {remainder, dividend/quotient}
  logic               neg_q;   // negate the selected result at the end
  logic [CntW-1:0]    cnt_q;
  logic [WIDTH-1:0]   result_q;
  logic               done_q;

  // Incoming op decode: signedness, magnitudes and the result-sign flag.
  logic             a_signed, b_signed, a_sgn, b_sgn, neg_in;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             div_zero, div_ovf, fast;
  logic [WIDTH-1:0] fast_res;

  always_comb begin
    a_signed = (funct3 == 3'b001) || (funct3 == 3'b010) ||
               (funct3 == 3'b100) || (funct3 == 3'b110);
    b_signed = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    a_sgn    = a_signed & a[WIDTH-1];
    b_sgn    = b_signed & b[WIDTH-1];
    a_mag    = a_sgn ? -a : a;
    b_mag    = b_sgn ? -b : b;
    unique case (funct3)
      3'b001, 3'b100: neg_in = a_sgn ^ b_sgn;
      // MULHSU sign comes from a alone; remainder sign follows the dividend.
      3'b010, 3'b110: neg_in = a_sgn;
      default:        neg_in = 1'b0;
    endcase

    div_zero = funct3[2] & (b == '0);
    div_ovf  = funct3[2] & ~funct3[0] & (a == MinNeg) & (b == '1);
    fast     = div_zero | div_ovf;
    if (funct3[1]) fast_res = div_zero ? a : '0;        // REM/REMU
    else           fast_res = div_zero ? '1 : MinNeg;   // DIV/DIVU
  end

  // One iteration of the datapath.
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_trial, div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] mul_next, div_next, step_next, mul_fin;
  logic [WIDTH-1:0]   div_sel, calc_res;

  always_comb begin
    mul_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, opb_q} : '0);
    mul_next  = {mul_sum, prod_q[WIDTH-1:1]};

    div_trial = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
    div_diff  = div_trial - {1'b0, opb_q};
    // Remainder stays below the divisor, so bit WIDTH of the difference is the borrow.
    div_ge    = ~div_diff[WIDTH];
    div_next  = div_ge ? {div_diff[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1}
                       : {div_trial[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b0};

    step_next = op_q[2] ? div_next : mul_next;

    // Multiply negates the full product before picking a half.
    mul_fin   = neg_q ? -step_next : step_next;
    div_sel   = op_q[1] ? step_next[2*WIDTH-1:WIDTH] : step_next[WIDTH-1:0];
    if (op_q[2])             calc_res = neg_q ? -div_sel : div_sel;
    else if (op_q[1:0] == 0) calc_res = mul_fin[WIDTH-1:0];
    else                     calc_res = mul_fin[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      op_q     <= '0;
      opb_q    <= '0;
      prod_q   <= '0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start && !flush) begin
            op_q  <= funct3;
            cnt_q <= '0;
            if (fast) begin
              result_q <= fast_res;
              done_q   <= 1'b1;
              state_q  <= StDone;
            end else begin
              opb_q   <= funct3[2] ? b_mag : a_mag;
              prod_q  <= {{WIDTH{1'b0}}, (funct3[2] ? a_mag : b_mag)};
              neg_q   <= neg_in;
              state_q <= StCalc;
            end
          end
        end
        StCalc: begin
          if (flush) begin
            state_q <= StIdle;
          end else begin
            prod_q <= step_next;
            cnt_q  <= cnt_q + CntW'(1);
            if (cnt_q == CntW'(WIDTH - 1)) begin
              result_q <= calc_res;
              done_q   <= 1'b1;
              state_q  <= StDone;
            end
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign stall  = ((state_q == StIdle) & start & ~flush) | (state_q == StCalc);
  assign busy   = (state_q != StIdle);
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;

  localparam logic [31:0] Min  = 32'h8000_0000;
  localparam logic [31:0] Ones = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        flush = 1'b0;
  logic        stall, busy, done;
  logic [31:0] result;

  muldiv_sequencer #(.WIDTH(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .funct3 (funct3),
    .a      (a),
    .b      (b),
    .flush  (flush),
    .stall  (stall),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    int          cyc;
  } exp_t;
  exp_t q[$];

  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_res = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at cycle %0d", name, act, expv, cyc);
    end
  endtask

  // Reference model: plain 64-bit arithmetic on the architectural definition.
  function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] x,
                                          input logic [31:0] y);
    longint          sx = longint'($signed(x));
    longint          sy = longint'($signed(y));
    longint unsigned ux = {32'b0, x};
    longint unsigned uy = {32'b0, y};
    logic [63:0]     t;
    case (f)
      3'd0: begin t = ux * uy; return t[31:0]; end
      3'd1: begin t = sx * sy; return t[63:32]; end
      3'd2: begin t = sx * longint'(uy); return t[63:32]; end
      3'd3: begin t = ux * uy; return t[63:32]; end
      3'd4: begin
        if (y == 0) return Ones;
        if (x == Min && y == Ones) return Min;
        t = sx / sy; return t[31:0];
      end
      3'd5: begin
        if (y == 0) return Ones;
        t = ux / uy; return t[31:0];
      end
      3'd6: begin
        if (y == 0) return x;
        if (x == Min && y == Ones) return 32'd0;
        t = sx % sy; return t[31:0];
      end
      default: begin
        if (y == 0) return x;
        t = ux % uy; return t[31:0];
      end
    endcase
  endfunction

  function automatic int latency(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    if (f[2] && (y == 0 || (!f[0] && x == Min && y == Ones))) return 1;
    return 33;
  endfunction

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return Min;
      2:       return Ones;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Monitor: pops the scoreboard on every done, otherwise checks the result holds.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("reset_result", result, 32'd0);
      chk("reset_done", {31'b0, done}, 32'd0);
      last_res = '0;
    end else if (done) begin
      if (q.size() == 0) begin
        chk("unexpected_done", {31'b0, done}, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("result", result, e.res);
        chk("done_cycle", cyc, e.cyc);
        last_res = e.res;
      end
    end else begin
      chk("result_hold", result, last_res);
    end
  end

  // Called just after a negedge with the DUT idle; returns at the next negedge.
  task automatic issue(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                       input bit push);
    exp_t e;
    funct3 = f;
    a      = x;
    b      = y;
    start  = 1'b1;
    if (push) begin
      e.res = ref_res(f, x, y);
      e.cyc = cyc + latency(f, x, y);
      q.push_back(e);
    end
    #1 chk("stall_on_start", {31'b0, stall}, 32'd1);
    @(negedge clk);
    start  = 1'b0;
    funct3 = 3'($urandom);
    a      = $urandom;
    b      = $urandom;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", {31'b0, busy}, 32'd0);
  endtask

  logic [2:0]  dir_f[10] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd7, 3'd4};
  logic [31:0] dir_a[10] = '{Ones, Ones, Ones, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                             32'd100, 32'd100, 32'd5, 32'd5, Min};
  logic [31:0] dir_b[10] = '{Ones, Ones, Ones, 32'd2, 32'd2, 32'd7, 32'd7, 32'd0, 32'd0, Ones};

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_stall", {31'b0, stall}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // MUL 7*6 with cycle-accurate stall/done/busy.
    issue(3'd0, 32'd7, 32'd6, 1'b1);
    for (int i = 1; i <= 32; i++) begin
      chk("stall_calc", {31'b0, stall}, 32'd1);
      @(negedge clk);
    end
    chk("stall_in_done", {31'b0, stall}, 32'd0);
    chk("done_at_33", {31'b0, done}, 32'd1);
    @(negedge clk);
    chk("busy_after_done", {31'b0, busy}, 32'd0);

    for (int i = 0; i < 10; i++) begin
      issue(dir_f[i], dir_a[i], dir_b[i], 1'b1);
      wait_idle();
    end

    // REM overflow fast path: done one cycle after start.
    issue(3'd6, Min, Ones, 1'b1);
    chk("fast_done", {31'b0, done}, 32'd1);
    wait_idle();

    // Flush mid-CALC: no done, result held, next op accepted.
    issue(3'd0, 32'd3, 32'd5, 1'b0);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", {31'b0, busy}, 32'd0);
    chk("flush_stall", {31'b0, stall}, 32'd0);
    repeat (40) @(negedge clk);
    issue(3'd0, 32'd9, 32'd9, 1'b1);
    wait_idle();

    // start with flush in the same cycle is not accepted.
    start = 1'b1;
    flush = 1'b1;
    #1 chk("start_flush_stall", {31'b0, stall}, 32'd0);
    @(negedge clk);
    start = 1'b0;
    flush = 1'b0;
    chk("start_flush_busy", {31'b0, busy}, 32'd0);

    // A second start during CALC is ignored.
    issue(3'd5, 32'd1000, 32'd7, 1'b1);
    repeat (5) @(negedge clk);
    funct3 = 3'd0;
    a      = 32'd2;
    b      = 32'd3;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();

    // Asynchronous reset mid-CALC.
    issue(3'd0, 32'd11, 32'd13, 1'b0);
    repeat (5) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_busy", {31'b0, busy}, 32'd0);
    chk("async_rst_done", {31'b0, done}, 32'd0);
    chk("async_rst_result", result, 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // Randomized ops against the reference model.
    for (int i = 0; i < 40; i++) begin
      issue(3'($urandom_range(0, 7)), rnd_operand(), rnd_operand(), 1'b1);
      wait_idle();
    end

    repeat (3) @(negedge clk);
    chk("pending_ops", q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
